// File: rtl/led_arbiter_pkg.sv
// Shared types and limits for the LED bank arbiter.
//   state_t  : arbiter FSM state encoding
//   NSRC_MAX : largest supported number of pattern sources
//   LED_W    : width of one LED pattern / the LED bank
package led_arbiter_pkg;

  localparam int unsigned NSRC_MAX = 8;
  localparam int unsigned LED_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/led_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector (level)
//   last : index of the most recent grantee
//   next : lowest requesting index above last, else lowest requesting index
//   any  : at least one request is active
module led_arbiter_rr_pick #(
  parameter int unsigned NSRC = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   next,
  output logic            any
);

  logic [IW-1:0] idx_hi;
  logic [IW-1:0] idx_lo;
  logic          has_hi;

  // Scan downwards so the final write holds the lowest matching index.
  always_comb begin
    idx_hi = '0;
    idx_lo = '0;
    has_hi = 1'b0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = IW'(i);
        if (IW'(i) > last) begin
          idx_hi = IW'(i);
          has_hi = 1'b1;
        end
      end
    end
  end

  assign next = has_hi ? idx_hi : idx_lo;
  assign any  = |req;

endmodule

// File: rtl/led_arbiter.sv
// Time-slices the 8-bit LED bank between NSRC pattern sources.
// Round-robin grant, fixed dwell of 2**CTR cycles per slice, GAP blank
// cycles between slices (GAP=0 hands over directly).
//   clk, rst : clock, synchronous active-high reset
//   req      : per-source request (level)
//   pat      : per-source pattern, source i at pat[8*i+7:8*i]
//   led      : registered LED drive
//   grant    : registered one-hot owner, zero when nobody owns the bank
//   busy     : registered, high in SHOW and BLANK
module led_arbiter
  import led_arbiter_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter int unsigned CTR  = 24,
  parameter int unsigned GAP  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSRC-1:0]       req,
  input  logic [NSRC*LED_W-1:0] pat,
  output logic [LED_W-1:0]      led,
  output logic [NSRC-1:0]       grant,
  output logic                  busy
);

  localparam int unsigned IW       = $clog2(NSRC);
  localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [NSRC-1:0] ONE  = NSRC'(1);

  if (NSRC < 2 || NSRC > NSRC_MAX) begin : g_bad_nsrc
    $error("led_arbiter: NSRC must be in 2..%0d", NSRC_MAX);
  end

  state_t             state, state_d;
  logic [CTR-1:0]     dwell, dwell_d;
  logic [GW-1:0]      gapcnt, gapcnt_d;
  logic [IW-1:0]      last, last_d;
  logic [LED_W-1:0]   led_d;
  logic [NSRC-1:0]    grant_d;
  logic               busy_d;

  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic               owner_req;
  logic               others;
  logic               terminal;
  logic               gap_last;
  logic               slice_end;
  logic               load;

  led_arbiter_rr_pick #(
    .NSRC (NSRC),
    .IW   (IW)
  ) u_pick (
    .req  (req),
    .last (last),
    .next (pick_idx),
    .any  (pick_any)
  );

  // While showing, 'last' is the current owner.
  assign owner_req = req[last];
  assign others    = |(req & ~(ONE << last));
  assign terminal  = &dwell;
  assign gap_last  = (gapcnt == GW'(GAP_LAST));
  // An owner drop wins over the terminal count; both end the slice.
  assign slice_end = !owner_req || (terminal && others);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (pick_any) state_d = ST_SHOW;
      ST_SHOW: begin
        if (slice_end) begin
          if (GAP != 0)       state_d = ST_BLANK;
          else if (!pick_any) state_d = ST_IDLE;
        end
      end
      ST_BLANK: if (gap_last) state_d = pick_any ? ST_SHOW : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next output/datapath values; a new slice loads the picked source.
  always_comb begin
    load     = 1'b0;
    led_d    = '0;
    grant_d  = '0;
    dwell_d  = '0;
    gapcnt_d = '0;
    last_d   = last;
    busy_d   = (state_d != ST_IDLE);
    unique case (state)
      ST_IDLE:  load = pick_any;
      ST_SHOW:  load = slice_end && (GAP == 0) && pick_any;
      ST_BLANK: load = gap_last && pick_any;
      default:  load = 1'b0;
    endcase
    if (load) begin
      last_d  = pick_idx;
      grant_d = ONE << pick_idx;
      led_d   = pat[{pick_idx, 3'b000} +: LED_W];
    end else if (state_d == ST_SHOW) begin
      grant_d = ONE << last;
      led_d   = pat[{last, 3'b000} +: LED_W];
      dwell_d = dwell + CTR'(1);
    end else if (state_d == ST_BLANK && state == ST_BLANK) begin
      gapcnt_d = gapcnt + GW'(1);
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      led    <= '0;
      grant  <= '0;
      busy   <= 1'b0;
      dwell  <= '0;
      gapcnt <= '0;
      last   <= IW'(NSRC - 1);
    end else begin
      led    <= led_d;
      grant  <= grant_d;
      busy   <= busy_d;
      dwell  <= dwell_d;
      gapcnt <= gapcnt_d;
      last   <= last_d;
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter with NSRC=4, CTR=4, GAP=2.
module tb_led_arbiter;

  localparam int SLICE = 16;
  localparam int GAPN  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  pv [4];
  logic [31:0] pat;
  logic [7:0]  led;
  logic [3:0]  grant;
  logic        busy;

  int total = 0;
  int bad   = 0;

  assign pat = {pv[3], pv[2], pv[1], pv[0]};

  always #5 clk = ~clk;

  led_arbiter #(.NSRC(4), .CTR(4), .GAP(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .pat   (pat),
    .led   (led),
    .grant (grant),
    .busy  (busy)
  );

  // Behavioural model: mode 0 idle, 1 showing, 2 blank.
  int         m_mode  = 0;
  int         m_owner = 0;
  int         m_age   = 0;
  int         m_gleft = 0;
  int         m_last  = 3;
  logic [7:0] m_led   = 8'h00;
  bit         m_valid = 1'b0;

  function automatic int pick(input logic [3:0] r, input int lst);
    for (int k = 1; k <= 4; k++)
      if (r[(lst + k) % 4]) return (lst + k) % 4;
    return -1;
  endfunction

  task start_slice();
    m_owner = pick(req, m_last);
    m_last  = m_owner;
    m_mode  = 1;
    m_age   = 1;
    m_led   = pv[m_owner];
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_owner = 0; m_age = 0; m_gleft = 0; m_last = 3;
      m_led = 8'h00; m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_mode)
        0: if (req != 4'b0000) start_slice();
        1: begin
          if (!req[m_owner] ||
              (m_age == SLICE && (req & ~(4'b0001 << m_owner)) != 4'b0000)) begin
            m_mode = 2; m_gleft = GAPN; m_led = 8'h00;
          end else begin
            m_age = (m_age == SLICE) ? 1 : m_age + 1;
            m_led = pv[m_owner];
          end
        end
        default: begin
          m_gleft--;
          if (m_gleft == 0) begin
            if (req != 4'b0000) start_slice();
            else begin m_mode = 0; m_led = 8'h00; end
          end
        end
      endcase
    end
  end

  // Compare DUT against the model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [3:0] eg;
      eg = (m_mode == 1) ? (4'b0001 << m_owner) : 4'b0000;
      total++;
      if (led !== m_led) begin
        bad++; $display("FAIL model_led t=%0t got %h want %h", $time, led, m_led);
      end
      total++;
      if (grant !== eg) begin
        bad++; $display("FAIL model_grant t=%0t got %b want %b", $time, grant, eg);
      end
      total++;
      if (busy !== (m_mode != 0)) begin
        bad++; $display("FAIL model_busy t=%0t got %b want %b", $time, busy, m_mode != 0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_out(input string name, input logic [7:0] el,
                           input logic [3:0] eg, input logic eb);
    check({name, "_led"},   32'(led),   32'(el));
    check({name, "_grant"}, 32'(grant), 32'(eg));
    check({name, "_busy"},  32'(busy),  32'(eb));
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 4; i++) pv[i] = 8'(8'h11 * (i + 1));
    step(2);
    check_out("reset", 8'h00, 4'b0000, 1'b0);
    rst = 1'b0;

    // Idle with no requests, then a single request.
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_out("idle", 8'h00, 4'b0000, 1'b0);
    end
    req = 4'b0100;
    step(1);
    check_out("first_grant", 8'h33, 4'b0100, 1'b1);
    req = 4'b0000;
    step(3);
    check_out("back_idle", 8'h00, 4'b0000, 1'b0);

    // Round-robin over sources 0, 1, 3.
    rst = 1'b1; step(1); rst = 1'b0;
    req = 4'b1011;
    step(1);
    check_out("rr0_start", 8'h11, 4'b0001, 1'b1);
    step(SLICE - 1);
    check_out("rr0_end", 8'h11, 4'b0001, 1'b1);
    step(1);
    check_out("rr_blank1", 8'h00, 4'b0000, 1'b1);
    step(1);
    check_out("rr_blank2", 8'h00, 4'b0000, 1'b1);
    step(1);
    check_out("rr1", 8'h22, 4'b0010, 1'b1);
    step(SLICE + GAPN);
    check_out("rr3", 8'h44, 4'b1000, 1'b1);
    step(SLICE + GAPN);
    check_out("rr0_again", 8'h11, 4'b0001, 1'b1);

    // Sole requester keeps the bank without blanking.
    req = 4'b0001;
    for (int i = 0; i < 64; i++) begin
      step(1);
      check_out("sole", 8'h11, 4'b0001, 1'b1);
    end

    // Early drop at dwell 5.
    req = 4'b1010;
    step(1);
    check_out("drop0_blank", 8'h00, 4'b0000, 1'b1);
    step(2);
    check_out("own1", 8'h22, 4'b0010, 1'b1);
    step(5);
    req = 4'b1000;
    step(1);
    check_out("early_blank", 8'h00, 4'b0000, 1'b1);
    step(2);
    check_out("early_next", 8'h44, 4'b1000, 1'b1);

    // Drop coinciding with the terminal count.
    req = 4'b1010;
    step(SLICE + GAPN);
    check_out("own1_b", 8'h22, 4'b0010, 1'b1);
    step(SLICE - 1);
    req = 4'b1000;
    step(1);
    check_out("term_blank", 8'h00, 4'b0000, 1'b1);
    step(2);
    check_out("term_next", 8'h44, 4'b1000, 1'b1);

    // Live pattern pass-through with a one-cycle delay.
    req = 4'b0001;
    step(3);
    check_out("live_start", 8'h11, 4'b0001, 1'b1);
    for (int i = 0; i < 10; i++) begin
      pv[0] = pv[0] + 8'd1;
      step(1);
      check("live_led", 32'(led), 32'(pv[0]));
    end
    pv[0] = 8'h11;

    // Reset during SHOW and during BLANK.
    rst = 1'b1; step(1); rst = 1'b0;
    req = 4'b1111;
    step(1);
    check_out("rst_pre", 8'h11, 4'b0001, 1'b1);
    step(7);
    rst = 1'b1;
    step(1);
    check_out("rst_show", 8'h00, 4'b0000, 1'b0);
    rst = 1'b0;
    step(1);
    check_out("rst_show_next", 8'h11, 4'b0001, 1'b1);
    step(SLICE);
    check_out("rst_in_blank", 8'h00, 4'b0000, 1'b1);
    rst = 1'b1;
    step(1);
    check_out("rst_blank", 8'h00, 4'b0000, 1'b0);
    rst = 1'b0;
    step(1);
    check_out("rst_blank_next", 8'h11, 4'b0001, 1'b1);

    req = 4'b0000;
    step(5);
    check_out("final_idle", 8'h00, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
